// File: rtl/imm_encoder.sv
// Immediate encoder: inserts a 32-bit immediate into the I/S/B/J/U bit positions
// of a base instruction. Two-stage valid/ready pipeline: range check, then pack.
module imm_encoder #(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 inValid,
   output logic                 inReady,
   input  logic [31:0]          instrIn,
   input  logic [31:0]          immIn,
   input  logic [2:0]           immSelIn,
   output logic                 outValid,
   input  logic                 outReady,
   output logic [31:0]          instrOut,
   output logic                 immErr,
   output logic [ERR_CNT_W-1:0] errCnt
);

   localparam logic [2:0] SEL_I = 3'b000;
   localparam logic [2:0] SEL_B = 3'b001;
   localparam logic [2:0] SEL_J = 3'b010;
   localparam logic [2:0] SEL_S = 3'b011;
   localparam logic [2:0] SEL_U = 3'b100;

   localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

   logic        s1Valid;
   logic [31:0] s1Instr;
   logic [31:0] s1Imm;
   logic [2:0]  s1Sel;
   logic        s1Err;
   logic        s2Valid;
   logic        s2Adv;
   logic        rangeErr;
   logic [31:0] effImm;
   logic [31:0] packedWord;

   assign s2Adv    = !s2Valid || outReady;
   assign inReady  = rst_n && (!s1Valid || s2Adv);
   assign outValid = s2Valid;

   // Upper bits must be a pure sign extension of the field width the format can hold.
   always_comb begin
      rangeErr = 1'b1;
      case (immSelIn)
         SEL_I, SEL_S: rangeErr = !((&immIn[31:11]) || !(|immIn[31:11]));
         SEL_B:        rangeErr = !((&immIn[31:12]) || !(|immIn[31:12])) || immIn[0];
         SEL_J:        rangeErr = !((&immIn[31:20]) || !(|immIn[31:20])) || immIn[0];
         SEL_U:        rangeErr = |immIn[11:0];
         default:      rangeErr = 1'b1;
      endcase
   end

   // Zeroing the immediate on error clears exactly the format's immediate fields.
   always_comb begin
      effImm     = s1Err ? 32'd0 : s1Imm;
      packedWord = s1Instr;
      case (s1Sel)
         SEL_I: packedWord = {effImm[11:0], s1Instr[19:0]};
         SEL_S: packedWord = {effImm[11:5], s1Instr[24:12], effImm[4:0], s1Instr[6:0]};
         SEL_B: packedWord = {effImm[12], effImm[10:5], s1Instr[24:12],
                              effImm[4:1], effImm[11], s1Instr[6:0]};
         SEL_J: packedWord = {effImm[20], effImm[10:1], effImm[11],
                              effImm[19:12], s1Instr[11:0]};
         SEL_U: packedWord = {effImm[31:12], s1Instr[11:0]};
         default: packedWord = s1Instr;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1Valid  <= 1'b0;
         s2Valid  <= 1'b0;
         instrOut <= '0;
         immErr   <= 1'b0;
         errCnt   <= '0;
      end else begin
         if (inValid && inReady) begin
            s1Valid <= 1'b1;
         end else if (s2Adv) begin
            s1Valid <= 1'b0;
         end
         if (s2Adv) begin
            s2Valid <= s1Valid;
            if (s1Valid) begin
               instrOut <= packedWord;
               immErr   <= s1Err;
            end
         end
         if (s2Valid && outReady && immErr && (errCnt != {ERR_CNT_W{1'b1}})) begin
            errCnt <= errCnt + CNT_ONE;
         end
      end
   end

   // Stage-1 payload needs no reset; s1Valid qualifies it.
   always_ff @(posedge clk) begin
      if (inValid && inReady) begin
         s1Instr <= instrIn;
         s1Imm   <= immIn;
         s1Sel   <= immSelIn;
         s1Err   <= rangeErr;
      end
   end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: per-format encodes, boundaries, backpressure
// streaming and error-counter saturation with a 2-bit counter.
module tb_imm_encoder;

   logic        clk;
   logic        rst_n;
   logic        inValid;
   logic        inReady;
   logic [31:0] instrIn;
   logic [31:0] immIn;
   logic [2:0]  immSelIn;
   logic        outValid;
   logic        outReady;
   logic [31:0] instrOut;
   logic        immErr;
   logic [1:0]  errCnt;

   int vecs = 0;
   int errs = 0;

   imm_encoder #(.ERR_CNT_W(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .inValid  (inValid),
      .inReady  (inReady),
      .instrIn  (instrIn),
      .immIn    (immIn),
      .immSelIn (immSelIn),
      .outValid (outValid),
      .outReady (outReady),
      .instrOut (instrOut),
      .immErr   (immErr),
      .errCnt   (errCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Caller is 1ns after a rising edge with an empty pipeline and outReady=1.
   task automatic single(input string tag, input logic [31:0] ins, input logic [31:0] imm,
                         input logic [2:0] sel, input logic [31:0] expInstr, input logic expErr);
      instrIn  = ins;
      immIn    = imm;
      immSelIn = sel;
      inValid  = 1'b1;
      outReady = 1'b1;
      chk({tag, ".inReady"}, 32'(inReady), 32'd1);
      @(posedge clk); #1;
      inValid = 1'b0;
      chk({tag, ".lat1"}, 32'(outValid), 32'd0);
      @(posedge clk); #1;
      chk({tag, ".outValid"}, 32'(outValid), 32'd1);
      chk({tag, ".instr"}, instrOut, expInstr);
      chk({tag, ".immErr"}, 32'(immErr), 32'(expErr));
      $display("%s: instrOut=%h immErr=%0d", tag, instrOut, immErr);
      @(posedge clk); #1;
   endtask

   logic [31:0] streamImm [5] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
   logic [31:0] streamExp [5] = '{32'h00100013, 32'h00200013, 32'h00300013,
                                   32'h00400013, 32'h00500013};
   bit          rdyPat [24]   = '{1,0,0,1,1,0,1,0,0,0,1,1,1,1,1,1,1,1,1,1,1,1,1,1};
   logic [31:0] satInstr [5]  = '{32'h12345678, 32'hFFFFFFFF, 32'h00000000,
                                   32'hA5A5A5A5, 32'h80000001};
   logic [31:0] satCnt [5]    = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3};

   initial begin
      int sent;
      int got;
      int occ;
      logic prevStall;
      logic [31:0] prevInstr;
      logic prevErr;

      rst_n    = 1'b0;
      inValid  = 1'b1;
      instrIn  = 32'h00000013;
      immIn    = 32'd0;
      immSelIn = 3'b000;
      outReady = 1'b1;

      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("rst.inReady", 32'(inReady), 32'd0);
         chk("rst.outValid", 32'(outValid), 32'd0);
         chk("rst.errCnt", 32'(errCnt), 32'd0);
      end
      inValid = 1'b0;
      rst_n   = 1'b1;
      #1;
      chk("rst.release", 32'(inReady), 32'd1);
      @(posedge clk); #1;
      chk("rst.noOut", 32'(outValid), 32'd0);

      single("I.min",  32'h00000013, 32'hFFFFF800, 3'b000, 32'h80000013, 1'b0);
      single("I.max",  32'h00000013, 32'h000007FF, 3'b000, 32'h7FF00013, 1'b0);
      single("B.ok",   32'h00B50063, 32'h00000FFE, 3'b001, 32'h7EB50FE3, 1'b0);
      chk("B.ok.errCnt", 32'(errCnt), 32'd0);
      single("B.odd",  32'h00B50063, 32'h00000003, 3'b001, 32'h00B50063, 1'b1);
      chk("B.odd.errCnt", 32'(errCnt), 32'd1);
      single("J.min",  32'h0000006F, 32'hFFF00000, 3'b010, 32'h8000006F, 1'b0);
      single("J.b11",  32'h0000006F, 32'h00000800, 3'b010, 32'h0010006F, 1'b0);
      single("S.neg4", 32'h00A12023, 32'hFFFFFFFC, 3'b011, 32'hFEA12E23, 1'b0);
      single("S.over", 32'h00A12023, 32'h00000800, 3'b011, 32'h00A12023, 1'b1);
      chk("S.over.errCnt", 32'(errCnt), 32'd2);
      single("U.ok",   32'hFFFFF037, 32'h12345000, 3'b100, 32'h12345037, 1'b0);
      single("U.low",  32'hFFFFF037, 32'h12345001, 3'b100, 32'h00000037, 1'b1);
      chk("U.low.errCnt", 32'(errCnt), 32'd3);

      // Backpressure stream: I-format words with immediates 1..5.
      sent = 0;
      got = 0;
      occ = 0;
      prevStall = 1'b0;
      prevInstr = '0;
      prevErr = 1'b0;
      for (int c = 0; c < 24; c++) begin
         if (sent < 5) begin
            inValid  = 1'b1;
            instrIn  = 32'h00000013;
            immIn    = streamImm[sent];
            immSelIn = 3'b000;
         end else begin
            inValid = 1'b0;
         end
         outReady = rdyPat[c];
         @(negedge clk);
         if (prevStall) begin
            chk("bp.holdValid", 32'(outValid), 32'd1);
            chk("bp.holdInstr", instrOut, prevInstr);
            chk("bp.holdErr", 32'(immErr), 32'(prevErr));
         end
         chk("bp.inReady", 32'(inReady), 32'((occ == 2 && !outReady) ? 0 : 1));
         if (outValid && outReady) begin
            if (got < 5) begin
               chk("bp.order", instrOut, streamExp[got]);
               $display("bp: word %0d instrOut=%h", got, instrOut);
            end
            got++;
            occ--;
         end
         if (inValid && inReady) begin
            sent++;
            occ++;
         end
         prevStall = outValid && !outReady;
         prevInstr = instrOut;
         prevErr   = immErr;
         @(posedge clk); #1;
      end
      inValid = 1'b0;
      outReady = 1'b1;
      chk("bp.sent", 32'(sent), 32'd5);
      chk("bp.received", 32'(got), 32'd5);

      // Mid-operation reset drops the in-flight word.
      instrIn  = 32'h00000013;
      immIn    = 32'd7;
      immSelIn = 3'b000;
      inValid  = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      rst_n   = 1'b0;
      @(posedge clk); #1;
      chk("midrst.outValid", 32'(outValid), 32'd0);
      chk("midrst.errCnt", 32'(errCnt), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midrst.drop", 32'(outValid), 32'd0);
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) begin
         single($sformatf("sel111.%0d", i), satInstr[i], 32'h00000000, 3'b111, satInstr[i], 1'b1);
         chk($sformatf("sel111.%0d.errCnt", i), 32'(errCnt), satCnt[i]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
